// File: rtl/risc6_core.sv
// risc6_core -- single-cycle 32-bit RISC execution core.
//
// Each rising clock edge the core executes the instruction word presented
// on instr. The program counter, an 8 x 32-bit register file and a small
// data memory live here, and every architectural register is exported.
//
// Ports:
//   clk     system clock, all state commits on the rising edge
//   rst     asynchronous, active-high reset (clears pc, registers, DMEM, halt)
//   instr   instruction to execute this cycle (fetched externally at pc)
//   pc      current program counter (word index)
//   R0..R7  live register contents
//   halt    sticky halted flag, cleared only by rst
//
// Parameters:
//   DMEM_DEPTH  number of 32-bit data-memory words (power of two, >= 2);
//               the memory address is the low log2(DMEM_DEPTH) bits of R[rs1].
module risc6_core #(
    parameter int DMEM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] R0,
    output logic [31:0] R1,
    output logic [31:0] R2,
    output logic [31:0] R3,
    output logic [31:0] R4,
    output logic [31:0] R5,
    output logic [31:0] R6,
    output logic [31:0] R7,
    output logic        halt
);

    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [5:0] OP_LDI = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b000001;
    localparam logic [5:0] OP_SUB = 6'b000010;
    localparam logic [5:0] OP_AND = 6'b000011;
    localparam logic [5:0] OP_OR  = 6'b000100;
    localparam logic [5:0] OP_XOR = 6'b000101;
    localparam logic [5:0] OP_LDR = 6'b000110;
    localparam logic [5:0] OP_STR = 6'b000111;
    localparam logic [5:0] OP_SHL = 6'b001000;
    localparam logic [5:0] OP_SHR = 6'b001001;
    localparam logic [5:0] OP_JMP = 6'b001010;
    localparam logic [5:0] OP_BZ  = 6'b001011;
    localparam logic [5:0] OP_HLT = 6'b111111;

    // Architectural state
    logic [31:0] rf   [8];
    logic [31:0] dmem [DMEM_DEPTH];

    // Decode
    logic [5:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [31:0] imm;

    assign op  = instr[31:26];
    assign rd  = instr[25:23];
    assign rs1 = instr[22:20];
    assign rs2 = instr[19:17];
    assign imm = {9'd0, instr[22:0]};

    // Operands always come from pre-edge register values, so rd may alias
    // rs1/rs2 without any forwarding concerns.
    logic [31:0]   a, b, d;
    logic [AW-1:0] maddr;

    assign a     = rf[rs1];
    assign b     = rf[rs2];
    assign d     = rf[rd];
    assign maddr = a[AW-1:0];

    // Execute / next-state
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        mem_we;
    logic [31:0] pc_next;
    logic        halt_next;

    always_comb begin
        rf_we     = 1'b0;
        rf_wdata  = '0;
        mem_we    = 1'b0;
        pc_next   = pc + 32'd1;
        halt_next = halt;

        unique case (op)
            OP_LDI: begin rf_we = 1'b1; rf_wdata = imm;            end
            OP_ADD: begin rf_we = 1'b1; rf_wdata = a + b;          end
            OP_SUB: begin rf_we = 1'b1; rf_wdata = a - b;          end
            OP_AND: begin rf_we = 1'b1; rf_wdata = a & b;          end
            OP_OR:  begin rf_we = 1'b1; rf_wdata = a | b;          end
            OP_XOR: begin rf_we = 1'b1; rf_wdata = a ^ b;          end
            OP_LDR: begin rf_we = 1'b1; rf_wdata = dmem[maddr];    end
            OP_STR: begin mem_we = 1'b1;                           end
            OP_SHL: begin rf_we = 1'b1; rf_wdata = a << b[4:0];    end
            OP_SHR: begin rf_we = 1'b1; rf_wdata = a >> b[4:0];    end
            OP_JMP: begin pc_next = imm;                           end
            OP_BZ:  begin if (d == 32'd0) pc_next = imm;           end
            OP_HLT: begin halt_next = 1'b1; pc_next = pc;          end
            default: ;  // unassigned opcodes behave as NOP
        endcase

        // A halted core freezes everything until reset.
        if (halt) begin
            rf_we     = 1'b0;
            mem_we    = 1'b0;
            pc_next   = pc;
            halt_next = 1'b1;
        end
    end

    // State commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= '0;
            halt <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            pc   <= pc_next;
            halt <= halt_next;
            if (rf_we)  rf[rd]      <= rf_wdata;
            if (mem_we) dmem[maddr] <= d;
        end
    end

    assign R0 = rf[0];
    assign R1 = rf[1];
    assign R2 = rf[2];
    assign R3 = rf[3];
    assign R4 = rf[4];
    assign R5 = rf[5];
    assign R6 = rf[6];
    assign R7 = rf[7];

endmodule

// File: tb/tb_risc6_core.sv
// Self-checking bench for risc6_core: a behavioural ISA model runs alongside
// the DUT; a compare process checks pc, R0..R7 and halt every falling edge.
// Directed programs pin the model with literal expectations, then randomized
// instruction streams (with resets between rounds) exercise the rest.
module tb_risc6_core;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7;
    logic        halt;

    risc6_core #(.DMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3),
        .R4(R4), .R5(R5), .R6(R6), .R7(R7),
        .halt(halt)
    );

    always #5 clk = ~clk;

    logic [31:0] dr [8];
    assign dr[0] = R0; assign dr[1] = R1; assign dr[2] = R2; assign dr[3] = R3;
    assign dr[4] = R4; assign dr[5] = R5; assign dr[6] = R6; assign dr[7] = R7;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned m_pc;
    longint unsigned m_r   [8];
    longint unsigned m_mem [DEPTH];
    bit              m_halt;
    bit              cmp_en = 1'b0;

    function automatic void model_reset();
        m_pc = 0; m_halt = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    endfunction

    function automatic void model_exec(input logic [31:0] i);
        int op, rd, s1, s2;
        longint unsigned x, y, v, target;
        bit wr;
        if (m_halt) return;
        op = int'(i >> 26);
        rd = int'((i >> 23) & 7);
        s1 = int'((i >> 20) & 7);
        s2 = int'((i >> 17) & 7);
        target = longint'(i) % (1 << 23);
        x = m_r[s1]; y = m_r[s2];
        wr = 1; v = 0;
        case (op)
            0:  v = target;
            1:  v = (x + y) % 64'h1_0000_0000;
            2:  v = (x + 64'h1_0000_0000 - y) % 64'h1_0000_0000;
            3:  v = x & y;
            4:  v = x | y;
            5:  v = x ^ y;
            6:  v = m_mem[x % DEPTH];
            8:  v = (x * (64'd1 << (y % 32))) % 64'h1_0000_0000;
            9:  v = x / (64'd1 << (y % 32));
            default: wr = 0;
        endcase
        if (wr) m_r[rd] = v;
        if (op == 7) m_mem[x % DEPTH] = m_r[rd];
        if (op == 63) m_halt = 1;
        else if (op == 10) m_pc = target;
        else if (op == 11 && m_r[rd] == 0) m_pc = target;
        else m_pc = (m_pc + 1) % 64'h1_0000_0000;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", pc, m_pc[31:0]);
            chk("halt", {31'd0, halt}, {31'd0, m_halt});
            for (int k = 0; k < 8; k++) chk($sformatf("R%0d", k), dr[k], m_r[k][31:0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_r(input int op, input int rd, input int s1, input int s2);
        logic [5:0] o; logic [2:0] a, b, c;
        o = op[5:0]; a = rd[2:0]; b = s1[2:0]; c = s2[2:0];
        return {o, a, b, c, 17'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rd, input int imm);
        logic [5:0] o; logic [2:0] a; logic [22:0] m;
        o = op[5:0]; a = rd[2:0]; m = imm[22:0];
        return {o, a, m};
    endfunction

    task automatic step(input logic [31:0] i);
        instr = i;
        @(posedge clk);
        model_exec(i);
        @(negedge clk);
    endtask

    // Reset asserted asynchronously between edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_pc", pc, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_R%0d", k), dr[k], 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        int r, op;
        logic [25:0] low;
        logic [31:0] t;
        logic [5:0] o;
        r = $urandom_range(0, 199);
        if (r < 2)       op = 63;
        else if (r < 12) op = $urandom_range(12, 62);
        else             op = $urandom_range(0, 11);
        t = $urandom();
        low = t[25:0];
        if (op == 10 || op == 11) low[22:0] = 23'($urandom_range(0, 63));
        if (op == 0 && t[31]) low[22:0] = 23'($urandom_range(0, 40));
        o = op[5:0];
        return {o, low};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst   = 1'b1;
        instr = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_pc", pc, 32'd0);
        chk("init_halt", {31'd0, halt}, 32'd0);
        chk("init_R7", R7, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // LDI / ADD / SUB from literal encodings
        step(32'h0000_0002);
        chk("pc1", pc, 32'd1);
        step(32'h0080_0003);
        chk("pc2", pc, 32'd2);
        step(32'h0510_0000);
        chk("pc3", pc, 32'd3);
        step(32'h09A0_0000);
        chk("pc4", pc, 32'd4);
        chk("lit_R0", R0, 32'd2);
        chk("lit_R1", R1, 32'd3);
        chk("lit_R2", R2, 32'd5);
        chk("lit_R3", R3, 32'd3);

        // AND, wrap, shift amount masking
        step(enc_r(3, 0, 1, 2));
        chk("and", R0, 32'd1);
        step(enc_i(0, 5, 0));
        step(enc_i(0, 6, 1));
        step(enc_r(2, 7, 5, 6));
        chk("sub_wrap", R7, 32'hFFFF_FFFF);
        step(enc_i(0, 6, 33));
        step(enc_i(0, 5, 7));
        step(enc_r(8, 5, 5, 6));
        chk("shl33", R5, 32'd14);
        step(enc_r(9, 4, 7, 6));
        chk("shr33", R4, 32'h7FFF_FFFF);

        // memory and aliasing
        step(enc_r(7, 1, 2, 0));        // DMEM[5] = R1 = 3
        step(enc_r(6, 4, 2, 0));        // R4 = DMEM[5]
        chk("ldr", R4, 32'd3);
        step(enc_i(0, 6, 21));
        step(enc_i(0, 4, 0));
        step(enc_r(6, 4, 6, 0));        // address 21 -> word 5
        chk("ldr_alias", R4, 32'd3);
        step(enc_r(7, 0, 6, 0));        // DMEM[21 mod 16] = R0 = 1
        step(enc_r(6, 3, 2, 0));
        chk("str_alias", R3, 32'd1);

        // control flow
        step(enc_i(10, 0, 10));
        chk("jmp", pc, 32'd10);
        step(enc_i(11, 5, 40));         // R5 = 14, not taken
        chk("bz_nt", pc, 32'd11);
        step(enc_i(0, 5, 0));
        step(enc_i(11, 5, 40));
        chk("bz_t", pc, 32'd40);
        step(32'hD000_0000);            // unassigned opcode 52 -> NOP
        chk("nop", pc, 32'd41);

        // halt
        step(32'hFC00_0000);
        chk("hlt", {31'd0, halt}, 32'd1);
        chk("hlt_pc", pc, 32'd41);
        step(enc_i(0, 0, 123));
        chk("hlt_R0", R0, 32'd1);
        chk("hlt_pc2", pc, 32'd41);
        async_reset();
        chk("rst_clr_halt", {31'd0, halt}, 32'd0);

        // randomized programs, each round starting from a mid-run reset
        for (int rnd = 0; rnd < 12; rnd++) begin
            for (int n = 0; n < 250; n++) step(rand_instr());
            async_reset();
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
